// File: rtl/capture_gray_pipeline.sv
// Capture an RGB frame into an internal buffer, then replay it through an
// RGB-to-gray converter while a small FSM sequences capture, gray and filter.
module capture_gray_pipeline #(
  parameter int NPIX = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clear,
  input  logic       cam_valid,
  input  logic [7:0] cam_data,
  input  logic       rwm2_done,
  output logic       camera_enable,
  output logic       rwm2_enable,
  output logic       rw_2,
  output logic [7:0] gs_data,
  output logic       gs_valid,
  output logic       busy
);

  localparam int DEPTH = 3 * NPIX;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_PIX  = PW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, GRAY, FILTER} state_t;

  state_t state_q, state_d;
  logic camera_enable_q, camera_enable_d;
  logic rwm2_enable_q, rwm2_enable_d;
  logic rw_2_q, rw_2_d;
  logic busy_q, busy_d;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          rwm1_done_q, rwm1_done_d;
  logic          rd_stop_q, rd_stop_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]    r_q, r_d, g_q, g_d;
  logic [7:0]    gs_data_q, gs_data_d;
  logic          gs_valid_q, gs_valid_d;
  logic          gs_done_q, gs_done_d;

  logic          wr_en, rd_issue, pause, in_gray;
  logic [9:0]    sum;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start)       state_d = CAPTURE;
        CAPTURE: if (rwm1_done_q) state_d = GRAY;
        GRAY:    if (gs_done_q)   state_d = FILTER;
        FILTER:  if (rwm2_done)   state_d = IDLE;
        default:                  state_d = IDLE;
      endcase
    end
    // Outputs are decoded from the next state so they register with it.
    camera_enable_d = (state_d == CAPTURE);
    rwm2_enable_d   = (state_d == GRAY) || (state_d == FILTER);
    rw_2_d          = (state_d == GRAY);
    busy_d          = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      camera_enable_q <= 1'b0;
      rwm2_enable_q   <= 1'b0;
      rw_2_q          <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      camera_enable_q <= camera_enable_d;
      rwm2_enable_q   <= rwm2_enable_d;
      rw_2_q          <= rw_2_d;
      busy_q          <= busy_d;
    end
  end

  assign in_gray  = (state_q == GRAY);
  assign wr_en    = (state_q == CAPTURE) && cam_valid && !clear;
  assign pause    = rd_valid_q && (byte_cnt_q == 2'd2);
  assign rd_issue = in_gray && !pause && !rd_stop_q && !clear;
  assign sum      = {2'b00, r_q} + {1'b0, g_q, 1'b0} + {2'b00, rd_data_q};

  always_comb begin
    wptr_d      = wptr_q;
    rwm1_done_d = 1'b0;
    if (clear) begin
      wptr_d = '0;
    end else if (wr_en) begin
      if (wptr_q == LAST_ADDR) begin
        wptr_d      = '0;
        rwm1_done_d = 1'b1;
      end else begin
        wptr_d = wptr_q + AW'(1);
      end
    end

    rptr_d     = rptr_q;
    rd_stop_d  = rd_stop_q;
    rd_valid_d = rd_issue;
    if (clear || !in_gray) begin
      rptr_d    = '0;
      rd_stop_d = 1'b0;
    end else if (rd_issue) begin
      if (rptr_q == LAST_ADDR) rd_stop_d = 1'b1;
      else                     rptr_d    = rptr_q + AW'(1);
    end

    byte_cnt_d = byte_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    r_d        = r_q;
    g_d        = g_q;
    gs_data_d  = gs_data_q;
    gs_valid_d = 1'b0;
    gs_done_d  = 1'b0;
    if (clear) begin
      byte_cnt_d = 2'd0;
      pix_cnt_d  = '0;
    end else if (rd_valid_q) begin
      case (byte_cnt_q)
        2'd0: begin r_d = rd_data_q; byte_cnt_d = 2'd1; end
        2'd1: begin g_d = rd_data_q; byte_cnt_d = 2'd2; end
        default: begin
          gs_data_d  = sum[9:2];
          gs_valid_d = 1'b1;
          byte_cnt_d = 2'd0;
          if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d = '0;
            gs_done_d = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + PW'(1);
          end
        end
      endcase
    end
  end

  // The frame buffer itself is never reset; its contents are only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (wr_en)    mem[wptr_q] <= cam_data;
    if (rd_issue) rd_data_q   <= mem[rptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      rwm1_done_q <= 1'b0;
      rd_stop_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      byte_cnt_q  <= 2'd0;
      pix_cnt_q   <= '0;
      r_q         <= 8'd0;
      g_q         <= 8'd0;
      gs_data_q   <= 8'd0;
      gs_valid_q  <= 1'b0;
      gs_done_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rwm1_done_q <= rwm1_done_d;
      rd_stop_q   <= rd_stop_d;
      rd_valid_q  <= rd_valid_d;
      byte_cnt_q  <= byte_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      r_q         <= r_d;
      g_q         <= g_d;
      gs_data_q   <= gs_data_d;
      gs_valid_q  <= gs_valid_d;
      gs_done_q   <= gs_done_d;
    end
  end

  assign camera_enable = camera_enable_q;
  assign rwm2_enable   = rwm2_enable_q;
  assign rw_2          = rw_2_q;
  assign busy          = busy_q;
  assign gs_data       = gs_data_q;
  assign gs_valid      = gs_valid_q;

endmodule

// File: tb/tb_capture_gray_pipeline.sv
// Directed bench for capture_gray_pipeline with a 4-pixel frame and hand-computed gray values.
module tb_capture_gray_pipeline;

  localparam int NPIX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       cam_valid = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic       rwm2_done = 1'b0;
  logic       camera_enable, rwm2_enable, rw_2, gs_valid, busy;
  logic [7:0] gs_data;

  int total = 0;
  int bad = 0;

  logic [7:0] frame_bytes [12];
  logic [7:0] exp_gray [4];

  capture_gray_pipeline #(.NPIX(NPIX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .cam_valid(cam_valid), .cam_data(cam_data), .rwm2_done(rwm2_done),
    .camera_enable(camera_enable), .rwm2_enable(rwm2_enable), .rw_2(rw_2),
    .gs_data(gs_data), .gs_valid(gs_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    cam_valid = v;
    cam_data  = d;
    @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic loadFrame(input bit toggle);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, frame_bytes[i]);
      if (toggle) applyStimulus(1'b0, 8'hAA);
    end
    cam_valid = 1'b0;
  endtask

  task automatic collectGray(input int n, input int budget);
    int   seen = 0;
    int   cyc = 0;
    logic prev = 1'b0;
    while (seen < n && cyc < budget) begin
      if (gs_valid) begin
        checkOutput($sformatf("gs_data_px%0d", seen), gs_data, exp_gray[seen]);
        checkOutput("gs_valid_width", prev, 1'b0);
        seen++;
      end
      prev = gs_valid;
      @(negedge clk);
      cyc++;
    end
    checkOutput("gray_count", seen, n);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_cam_en"}, camera_enable, 1'b0);
    checkOutput({tag, "_rwm2_en"}, rwm2_enable, 1'b0);
    checkOutput({tag, "_rw2"}, rw_2, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset_gs_valid", gs_valid, 1'b0);
    checkOutput("reset_gs_data", gs_data, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 1: bytes arrive on every other cycle.
    frame_bytes = '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'hFF, 8'hFF,
                    8'h00, 8'h00, 8'h00, 8'h11, 8'h05, 8'h33};
    exp_gray    = '{8'h80, 8'hFF, 8'h00, 8'h13};
    pulseStart();
    checkOutput("start_cam_en", camera_enable, 1'b1);
    checkOutput("start_busy", busy, 1'b1);
    loadFrame(1'b1);
    checkOutput("gray_rwm2_en", rwm2_enable, 1'b1);
    checkOutput("gray_rw2", rw_2, 1'b1);
    checkOutput("gray_cam_en", camera_enable, 1'b0);
    checkOutput("gray_busy", busy, 1'b1);
    collectGray(4, 60);
    checkOutput("filter_rw2", rw_2, 1'b0);
    checkOutput("filter_rwm2_en", rwm2_enable, 1'b1);
    checkOutput("filter_gs_valid", gs_valid, 1'b0);
    checkOutput("hold_gs_data", gs_data, 8'h13);

    pulseStart();
    checkOutput("filter_start_ignored_cam", camera_enable, 1'b0);
    checkOutput("filter_start_ignored_en", rwm2_enable, 1'b1);
    rwm2_done = 1'b1;
    @(negedge clk);
    rwm2_done = 1'b0;
    checkIdleOutputs("done");
    checkOutput("done_gs_data_hold", gs_data, 8'h13);

    // Frame 2: contiguous bytes, interrupted by reset during gray conversion.
    frame_bytes = '{8'hC0, 8'h80, 8'h40, 8'h10, 8'h20, 8'h30,
                    8'hFF, 8'h00, 8'hFF, 8'h08, 8'h04, 8'h00};
    exp_gray    = '{8'h80, 8'h20, 8'h7F, 8'h04};
    pulseStart();
    checkOutput("restart_cam_en", camera_enable, 1'b1);
    checkOutput("restart_busy", busy, 1'b1);
    loadFrame(1'b0);
    checkOutput("f2_still_capture", camera_enable, 1'b1);
    @(negedge clk);
    checkOutput("f2_gray_rw2", rw_2, 1'b1);
    collectGray(2, 40);
    #1 rst_n = 1'b0;
    #1;
    checkIdleOutputs("async_reset");
    checkOutput("async_reset_gs_valid", gs_valid, 1'b0);
    checkOutput("async_reset_gs_data", gs_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clear during capture, then start and clear together.
    pulseStart();
    checkOutput("pre_clear_cam_en", camera_enable, 1'b1);
    applyStimulus(1'b1, 8'h12);
    applyStimulus(1'b1, 8'h34);
    cam_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkIdleOutputs("clear");
    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    checkOutput("start_clear_busy", busy, 1'b0);
    rwm2_done = 1'b1;
    @(negedge clk);
    rwm2_done = 1'b0;
    checkOutput("idle_rwm2_done_busy", busy, 1'b0);
    checkOutput("idle_rwm2_done_en", rwm2_enable, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_gray_pipeline.md
CAPTURE_GRAY_PIPELINE -- requirements
Module: capture_gray_pipeline

Interface
REQ-001 Parameter NPIX, default 64, meaning pixels per frame; frame buffer depth is 3*NPIX bytes (R,G,B interleaved).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin a frame sequence; honoured only in IDLE.
REQ-005 clear  input  1  synchronous clear: pointers, counters and FSM back to their reset values; buffer contents untouched.
REQ-006 cam_valid  input  1  camera byte qualifier.
REQ-007 cam_data  input  8  camera byte, order R,G,B per pixel.
REQ-008 rwm2_done  input  1  one-cycle pulse from the downstream buffer: readout finished.
REQ-009 camera_enable  output  1  camera stream request.
REQ-010 rwm2_enable  output  1  downstream buffer enable.
REQ-011 rw_2  output  1  downstream buffer direction, 1=write, 0=read.
REQ-012 gs_data  output  8  grayscale pixel.
REQ-013 gs_valid  output  1  gs_data qualifier, one cycle per pixel.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 Controller FSM states: IDLE, CAPTURE, GRAY, FILTER; state and all outputs are registered (Moore).
REQ-016 IDLE->CAPTURE on start; CAPTURE->GRAY on internal rwm1_done; GRAY->FILTER on internal gs_done; FILTER->IDLE on rwm2_done; otherwise hold.
REQ-017 CAPTURE: camera_enable=1, buffer enabled in write mode; GRAY: buffer in read mode, grayscaler enabled, rwm2_enable=1, rw_2=1; FILTER: rwm2_enable=1, rw_2=0; IDLE: all enables 0, rw_2=0.
REQ-018 Write: each cycle in CAPTURE with cam_valid=1 stores cam_data at wptr, wptr increments; no write when cam_valid=0.
REQ-019 Writing byte 3*NPIX-1 pulses rwm1_done for exactly one cycle, the cycle after that write, and wptr wraps to 0.
REQ-020 Read: each GRAY cycle with pause=0 issues a read at rptr and rptr increments; data plus an internal valid appear one cycle later (1-cycle latency).
REQ-021 pause=1 suppresses read issue and holds rptr; a read already issued still delivers its byte.
REQ-022 Issuing byte 3*NPIX-1 stops further issues; rptr wraps to 0 on leaving GRAY.
REQ-023 Grayscaler counts valid bytes modulo 3 into R, G, B registers; on the B byte it computes gray=(R+2G+B)>>2 from a 10-bit sum (never overflows, result 0..255).
REQ-024 gs_data/gs_valid register the gray value the cycle after the B byte arrives; gs_valid lasts exactly one cycle.
REQ-025 pause asserts for exactly the one cycle in which the B byte is received.
REQ-026 Grayscaler counts pixels; gs_done pulses one cycle, coincident with gs_valid of pixel NPIX-1; pixel counter then wraps to 0.
REQ-027 Simultaneous start and clear: clear wins, FSM stays IDLE.
REQ-028 rwm2_done outside FILTER is ignored; start outside IDLE is ignored.
REQ-029 gs_data holds its last value while gs_valid=0.

Reset
REQ-030 rst_n=0 immediately forces: FSM=IDLE, all enables 0, rw_2=0, busy=0, gs_valid=0, gs_data=0, pause=0, pointers and counters 0, internal done pulses 0.
REQ-031 Reset mid-frame aborts the sequence; buffer contents are undefined until a new capture.
REQ-032 clear applies the REQ-030 values, except gs_data, synchronously on the next edge.

Verification
REQ-033 Reset, then one-cycle start -> next edge camera_enable=1, busy=1; 3*NPIX valid bytes -> rwm1_done pulse, FSM to GRAY, rwm2_enable=1, rw_2=1.
REQ-034 Pixel R=0x40, G=0x80, B=0xC0 -> gs_valid one cycle later with gs_data=0x80; R=G=B=0xFF -> 0xFF; all 0 -> 0x00.
REQ-035 NPIX=4, cam_valid toggling 1,0,1,0 -> exactly 12 bytes stored and 4 gs_valid pulses in order, with gs_done on the 4th.
REQ-036 In FILTER: rwm2_done pulse -> IDLE, busy=0, all enables 0; start then re-enters CAPTURE with wptr=0.
REQ-037 rst_n low during GRAY -> outputs reach REQ-030 values without a clock edge; clear during CAPTURE -> IDLE on the next edge.
